seg_display_scan: RTL and testbench

Multiplexed 7-segment display driver that feeds the team's 3-to-8 digit-select decoder. It accepts a binary reading through a valid/ready handshake and converts it to BCD sequentially (double-dabble). It then scans the digits at a fixed refresh rate, driving the digit index, the digit count and the active-low segment cathodes. The digit decoder turns the index and count into anode enables and the dot.

---
 rtl/seg_display_pkg.sv | 16 +
 rtl/seg_display_scan_bcd_to_seg7.sv | 25 ++
 rtl/seg_display_scan.sv | 130 +++++++++++++
 tb/tb_seg_display_scan.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg_display_pkg;

    typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned MAX_DISPLAY = 9999;

    localparam logic [2:0] NUM_BLANK = 3'd0;
    localparam logic [2:0] NUM_3     = 3'd3;
    localparam logic [2:0] NUM_4     = 3'd4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_display_scan_bcd_to_seg7.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} glyph; non-decimal codes blank.
module bcd_to_seg7
    import seg_display_pkg::*;
(
    input  bcd_digit_t digit,
    output logic [6:0] seg_n
);

    always_comb begin
        unique case (digit)
            4'd0:    seg_n = 7'h40;
            4'd1:    seg_n = 7'h79;
            4'd2:    seg_n = 7'h24;
            4'd3:    seg_n = 7'h30;
            4'd4:    seg_n = 7'h19;
            4'd5:    seg_n = 7'h12;
            4'd6:    seg_n = 7'h02;
            4'd7:    seg_n = 7'h78;
            4'd8:    seg_n = 7'h00;
            4'd9:    seg_n = 7'h10;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_scan.sv
// Handshaked binary input, sequential double-dabble to BCD, then timed digit scan.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant nonzero one.
module seg_display_scan
    import seg_display_pkg::*;
#(
    parameter int unsigned VAL_W    = 14,
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             val_valid,
    input  logic [VAL_W-1:0] val_data,
    output logic             val_ready,
    output logic [2:0]       a,
    output logic [2:0]       num,
    output logic [6:0]       seg_n,
    output logic             busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(VAL_W + 1);

    state_e           state;
    logic [VAL_W-1:0] bin_q;
    logic [15:0]      bcd_q;
    logic [11:0]      bcd_adj;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    presc_q, presc_d;
    bcd_digit_t       shadow_q [4];
    bcd_digit_t       shadow_d [4];
    bcd_digit_t       sel_digit;
    logic [2:0]       a_d, num_d;
    logic [6:0]       seg_pat, seg_d;
    logic [3:0]       lz;
    logic             commit, tick;

    // The thousands digit never reaches 5 before its last shift for values <= 9999,
    // so only the lower three digits need the add-3 correction.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                            : bcd_q[4*i +: 4];
        end
    end

    // Display next state: everything below is computed for the upcoming edge so that
    // a, num, the shadow digits and seg_n all switch together.
    always_comb begin
        commit  = (state == StCommit);
        tick    = (presc_q == PW'(TICK_DIV - 1));
        num_d   = num;
        for (int i = 0; i < 4; i++) shadow_d[i] = shadow_q[i];
        if (commit) begin
            num_d = (bcd_q[15:12] != 4'd0) ? NUM_4 : NUM_3;
            for (int i = 0; i < 4; i++) shadow_d[i] = bcd_q[4*i +: 4];
        end
        presc_d = tick ? '0 : presc_q + PW'(1);
        a_d     = a;
        if (commit && (a >= num_d)) begin
            a_d     = '0;
            presc_d = '0;
        end else if (tick) begin
            a_d = ((num_d == NUM_BLANK) || (a + 3'd1 >= num_d)) ? 3'd0 : a + 3'd1;
        end
    end

    always_comb begin
        lz = '0;
`ifdef LEADING_ZERO_BLANK_EN
        lz[3] = (shadow_d[3] == 4'd0);
        lz[2] = lz[3] && (shadow_d[2] == 4'd0);
        lz[1] = lz[2] && (shadow_d[1] == 4'd0);
`endif
        sel_digit = shadow_d[a_d[1:0]];
        seg_d = ((num_d == NUM_BLANK) || (a_d >= num_d) || lz[a_d[1:0]]) ? SEG_BLANK : seg_pat;
    end

    bcd_to_seg7 u_bcd_to_seg7 (
        .digit (sel_digit),
        .seg_n (seg_pat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            val_ready <= 1'b1;
            busy      <= 1'b0;
            presc_q   <= '0;
            a         <= '0;
            num       <= NUM_BLANK;
            seg_n     <= SEG_BLANK;
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
        end else begin
            presc_q <= presc_d;
            a       <= a_d;
            num     <= num_d;
            seg_n   <= seg_d;
            for (int i = 0; i < 4; i++) shadow_q[i] <= shadow_d[i];
            unique case (state)
                StIdle: begin
                    if (val_valid && val_ready) begin
                        bin_q     <= (32'(val_data) > 32'(MAX_DISPLAY)) ? VAL_W'(MAX_DISPLAY)
                                                                         : val_data;
                        bcd_q     <= '0;
                        cnt_q     <= '0;
                        state     <= StConvert;
                        val_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                StConvert: begin
                    bcd_q <= {bcd_q[14:12], bcd_adj, bin_q[VAL_W-1]};
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(VAL_W - 1)) state <= StCommit;
                end
                StCommit: begin
                    state     <= StIdle;
                    val_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with a fast prescaler; optionally built with
// LEADING_ZERO_BLANK_EN to check the blanked leading-zero glyphs.
module tb_seg_display_scan;

    localparam int unsigned VAL_W    = 14;
    localparam int unsigned TICK_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZL = 7'h7F;
`else
    localparam logic [6:0] ZL = 7'h40;
`endif

    typedef struct packed {
        logic [13:0]      val;
        logic [2:0]       num;
        logic [3:0][6:0]  seg;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             val_valid;
    logic [VAL_W-1:0] val_data;
    logic             val_ready;
    logic [2:0]       a;
    logic [2:0]       num;
    logic [6:0]       seg_n;
    logic             busy;

    int   checks;
    int   errors;
    int   t;
    int   exp_a;
    int   exp_num;
    vec_t vecs [8];
    vec_t prev;
    vec_t blank;

    seg_display_scan #(
        .VAL_W    (VAL_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .val_valid (val_valid),
        .val_data  (val_data),
        .val_ready (val_ready),
        .a         (a),
        .num       (num),
        .seg_n     (seg_n),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [13:0] v, input logic [2:0] n,
                                input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3);
        vec_t r;
        r.val = v;
        r.num = n;
        r.seg[0] = s0;
        r.seg[1] = s1;
        r.seg[2] = s2;
        r.seg[3] = s3;
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input vec_t v, input int ai);
        if (v.num == 3'd0 || ai >= int'(v.num)) return 7'h7F;
        return v.seg[ai];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Advances one edge and updates the expected scan position.
    task automatic step(input bit commit_edge, input logic [2:0] new_num);
        @(posedge clk);
        #1;
        if (commit_edge) exp_num = int'(new_num);
        if (commit_edge && exp_a >= exp_num) begin
            exp_a = 0;
            t     = 0;
        end else begin
            t = (t + 1) % TICK_DIV;
            if (t == 0) exp_a = (exp_num == 0 || exp_a + 1 >= exp_num) ? 0 : exp_a + 1;
        end
    endtask

    task automatic check_display(input string tag, input vec_t v);
        chk($sformatf("%s_a", tag), 32'(a), 32'(exp_a));
        chk($sformatf("%s_num", tag), 32'(num), 32'(v.num));
        chk($sformatf("%s_seg", tag), 32'(seg_n), 32'(exp_seg(v, exp_a)));
    endtask

    task automatic do_load(input int vi, input bit hold, input logic [13:0] hold_val);
        val_valid = 1'b1;
        val_data  = vecs[vi].val;
        step(1'b0, 3'd0);
        chk("accept_ready", 32'(val_ready), 32'd0);
        chk("accept_busy", 32'(busy), 32'd1);
        if (hold) val_data = hold_val;
        else val_valid = 1'b0;
        for (int k = 0; k < int'(VAL_W); k++) begin
            step(1'b0, 3'd0);
            chk("conv_ready", 32'(val_ready), 32'd0);
            chk("conv_busy", 32'(busy), 32'd1);
            check_display("conv", prev);
        end
        step(1'b1, vecs[vi].num);
        chk("commit_ready", 32'(val_ready), 32'd1);
        chk("commit_busy", 32'(busy), 32'd0);
        prev = vecs[vi];
        check_display($sformatf("commit%0d", vecs[vi].val), prev);
    endtask

    task automatic observe();
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 3'd0);
            check_display($sformatf("scan%0d", prev.val), prev);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        val_valid = 1'b0;
        val_data  = '0;
        blank     = mk(14'd0, 3'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        vecs[0]   = mk(14'd123,   3'd3, 7'h30, 7'h24, 7'h79, 7'h7F);
        vecs[1]   = mk(14'd9876,  3'd4, 7'h02, 7'h78, 7'h00, 7'h10);
        vecs[2]   = mk(14'd45,    3'd3, 7'h12, 7'h19, ZL,    7'h7F);
        vecs[3]   = mk(14'd12000, 3'd4, 7'h10, 7'h10, 7'h10, 7'h10);
        vecs[4]   = mk(14'd7,     3'd3, 7'h78, ZL,    ZL,    7'h7F);
        vecs[5]   = mk(14'd0,     3'd3, 7'h40, ZL,    ZL,    7'h7F);
        vecs[6]   = mk(14'd1000,  3'd4, 7'h40, 7'h40, 7'h40, 7'h79);
        vecs[7]   = mk(14'd5,     3'd3, 7'h12, ZL,    ZL,    7'h7F);

        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        t       = 0;
        exp_a   = 0;
        exp_num = 0;
        prev    = blank;
        chk("rst_ready", 32'(val_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        check_display("rst", blank);

        for (int k = 0; k < 40; k++) begin
            step(1'b0, 3'd0);
            check_display("idle", blank);
            chk("idle_ready", 32'(val_ready), 32'd1);
        end

        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                // Start the load so that the commit edge sees a == 3 with num 4.
                for (int k = 0; k < 16 && ((exp_a + ((t % 4) + 15) / 4) % 4) != 3; k++)
                    step(1'b0, 3'd0);
                chk("align_num", 32'(num), 32'd4);
                do_load(i, 1'b0, 14'd0);
                chk("forced_a", 32'(a), 32'd0);
                chk("forced_seg", 32'(seg_n), 32'h12);
            end else begin
                do_load(i, 1'b0, 14'd0);
            end
            observe();
        end

        // val_valid held high with 5 throughout the 45 conversion: taken only once ready.
        do_load(2, 1'b1, 14'd5);
        do_load(7, 1'b0, 14'd0);
        observe();

        // Reset in the fifth conversion cycle.
        val_valid = 1'b1;
        val_data  = 14'd9876;
        step(1'b0, 3'd0);
        val_valid = 1'b0;
        repeat (4) step(1'b0, 3'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        t       = 0;
        exp_a   = 0;
        exp_num = 0;
        prev    = blank;
        chk("midrst_ready", 32'(val_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        check_display("midrst", blank);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 3'd0);
            check_display("postrst", blank);
            chk("postrst_busy", 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
